// File: rtl/seq_sync_pkg.sv
// Shared types and helpers for the serial frame-sync controller.
package seq_sync_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCK   = 2'd2
  } sync_state_t;

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int pos_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_match_shreg.sv
// Serial pattern matcher: history shift register, fill counter and comparator.
module seq_match_shreg #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b0110
) (
  input  logic clk,
  input  logic rst,
  input  logic x,
  input  logic en,
  output logic match
);

  localparam int             FW       = $clog2(PAT_W);
  localparam logic [FW-1:0]  FILL_MAX = FW'(PAT_W - 1);

  logic [PAT_W-2:0] sh;
  logic [FW-1:0]    fill;
  logic [PAT_W-1:0] win;

  assign win = {sh, x};

  // The fill guard keeps the zeroed history from completing a pattern after reset.
  assign match = en && (win == PATTERN) && (fill == FILL_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh   <= '0;
      fill <= '0;
    end else if (en) begin
      sh <= win[PAT_W-2:0];
      if (fill != FILL_MAX) fill <= fill + 1'b1;
    end
  end

endmodule

// File: rtl/seq_frame_sync_ctrl.sv
// Frame-sync controller: hunts for the sync word, verifies its period,
// holds lock with miss tolerance and strobes out payload bits.
module seq_frame_sync_ctrl
  import seq_sync_pkg::*;
#(
  parameter int               PAT_W     = 4,
  parameter logic [PAT_W-1:0] PATTERN   = 4'b0110,
  parameter int               FRAME_LEN = 16,
  parameter int               LOCK_CNT  = 2,
  parameter int               MISS_CNT  = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  x,
  input  logic                                  en,
  output logic                                  locked,
  output logic                                  sync_pulse,
  output logic                                  data_out,
  output logic                                  data_valid,
  output logic [$clog2(FRAME_LEN-PAT_W)-1:0]    bit_idx
);

  localparam int             PW       = pos_width(FRAME_LEN);
  localparam int             IW       = $clog2(FRAME_LEN - PAT_W);
  localparam int             HW       = $clog2(LOCK_CNT + 1);
  localparam int             MW       = $clog2(MISS_CNT + 1);
  localparam logic [PW-1:0]  POS_LAST = PW'(FRAME_LEN - 1);
  localparam logic [PW-1:0]  PAY_LAST = PW'(FRAME_LEN - PAT_W);
  localparam logic [HW-1:0]  LOCK_N   = HW'(LOCK_CNT);
  localparam logic [MW-1:0]  MISS_N   = MW'(MISS_CNT);

  sync_state_t   state, state_nxt;
  logic [PW-1:0] pos, pos_nxt;
  logic [HW-1:0] hits, hits_nxt, hits_inc;
  logic [MW-1:0] misses, misses_nxt, misses_inc;
  logic          sync_nxt, valid_nxt, at_check, match;

  seq_match_shreg #(
    .PAT_W   (PAT_W),
    .PATTERN (PATTERN)
  ) u_match (
    .clk   (clk),
    .rst   (rst),
    .x     (x),
    .en    (en),
    .match (match)
  );

  assign at_check   = (pos == POS_LAST);
  assign hits_inc   = hits + 1'b1;
  assign misses_inc = misses + 1'b1;

  always_comb begin
    state_nxt  = state;
    pos_nxt    = pos;
    hits_nxt   = hits;
    misses_nxt = misses;
    sync_nxt   = 1'b0;
    valid_nxt  = 1'b0;
    if (en) begin
      pos_nxt = at_check ? '0 : pos + 1'b1;
      case (state)
        HUNT: begin
          if (match) begin
            state_nxt = VERIFY;
            pos_nxt   = '0;
            hits_nxt  = HW'(1);
            sync_nxt  = 1'b1;
          end
        end
        VERIFY: begin
          if (at_check) begin
            if (match) begin
              sync_nxt = 1'b1;
              hits_nxt = hits_inc;
              if (hits_inc == LOCK_N) begin
                state_nxt  = LOCK;
                misses_nxt = '0;
              end
            end else begin
              state_nxt = HUNT;
              hits_nxt  = '0;
            end
          end
        end
        LOCK: begin
          // A check point always lands on pos 0, so it can never qualify as payload.
          valid_nxt = (pos_nxt != '0) && (pos_nxt <= PAY_LAST);
          if (at_check) begin
            if (match) begin
              sync_nxt   = 1'b1;
              misses_nxt = '0;
            end else if (misses_inc == MISS_N) begin
              state_nxt  = HUNT;
              misses_nxt = '0;
              hits_nxt   = '0;
            end else begin
              misses_nxt = misses_inc;
            end
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= HUNT;
      pos        <= '0;
      hits       <= '0;
      misses     <= '0;
      locked     <= 1'b0;
      sync_pulse <= 1'b0;
      data_valid <= 1'b0;
      data_out   <= 1'b0;
      bit_idx    <= '0;
    end else begin
      state      <= state_nxt;
      pos        <= pos_nxt;
      hits       <= hits_nxt;
      misses     <= misses_nxt;
      locked     <= (state_nxt == LOCK);
      sync_pulse <= sync_nxt;
      data_valid <= valid_nxt;
      if (valid_nxt) begin
        data_out <= x;
        bit_idx  <= IW'(pos_nxt - 1'b1);
      end
    end
  end

endmodule

// File: tb/tb_seq_frame_sync_ctrl.sv
// Scoreboard bench for seq_frame_sync_ctrl with default parameters.
module tb_seq_frame_sync_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       x   = 1'b0;
  logic       en  = 1'b0;
  logic       locked, sync_pulse, data_out, data_valid;
  logic [3:0] bit_idx;

  typedef struct {
    logic       s;
    logic       v;
    logic       d;
    logic [3:0] i;
    logic       l;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  int   n_chk = 0;
  int   n_err = 0;
  logic       exp_locked = 1'b0;
  logic       last_dout  = 1'b0;
  logic [3:0] last_idx   = 4'd0;

  seq_frame_sync_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .x          (x),
    .en         (en),
    .locked     (locked),
    .sync_pulse (sync_pulse),
    .data_out   (data_out),
    .data_valid (data_valid),
    .bit_idx    (bit_idx)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk_eq("sync_pulse", 32'(sync_pulse), 32'(e.s));
      chk_eq("data_valid", 32'(data_valid), 32'(e.v));
      chk_eq("data_out",   32'(data_out),   32'(e.d));
      chk_eq("bit_idx",    32'(bit_idx),    32'(e.i));
      chk_eq("locked",     32'(locked),     32'(e.l));
    end
  end

  task automatic send_bit(input logic b, input logic e_sync, input logic e_valid,
                          input logic [3:0] e_idx);
    @(negedge clk);
    x  = b;
    en = 1'b1;
    @(posedge clk);
    if (e_valid) begin
      last_dout = b;
      last_idx  = e_idx;
    end
    sb.push_back('{s: e_sync, v: e_valid, d: last_dout, i: last_idx, l: exp_locked});
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      en = 1'b0;
      x  = ~x;
      @(posedge clk);
      sb.push_back('{s: 1'b0, v: 1'b0, d: last_dout, i: last_idx, l: exp_locked});
    end
  endtask

  // Sends a 4-bit word MSB first; locked expectation changes after its last bit.
  task automatic send_word(input logic [3:0] w, input logic sync_last, input logic lock_after);
    for (int k = 3; k >= 0; k--) begin
      if (k == 0) exp_locked = lock_after;
      send_bit(w[k], (k == 0) && sync_last, 1'b0, 4'd0);
    end
  endtask

  task automatic send_payload(input int n, input int start_idx, input logic valid);
    logic [31:0] r;
    for (int k = 0; k < n; k++) begin
      r = $urandom;
      send_bit(r[0], 1'b0, valid, 4'(start_idx + k));
    end
  endtask

  task automatic lock_up();
    send_word(4'b0110, 1'b1, 1'b0);
    send_payload(12, 0, 1'b0);
    send_word(4'b0110, 1'b1, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    en  = 1'b0;
    x   = 1'b0;
    #1;
    chk_eq("rst_locked", 32'(locked),     32'd0);
    chk_eq("rst_sync",   32'(sync_pulse), 32'd0);
    chk_eq("rst_valid",  32'(data_valid), 32'd0);
    chk_eq("rst_dout",   32'(data_out),   32'd0);
    chk_eq("rst_idx",    32'(bit_idx),    32'd0);
    exp_locked = 1'b0;
    last_dout  = 1'b0;
    last_idx   = 4'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset-zero history plus "110" must not match; 0110 after it does
    do_reset();
    send_bit(1'b1, 1'b0, 1'b0, 4'd0);
    send_bit(1'b1, 1'b0, 1'b0, 4'd0);
    send_bit(1'b0, 1'b0, 1'b0, 4'd0);
    send_word(4'b0110, 1'b1, 1'b0);

    // 2: two spaced syncs lock, then a full payload
    do_reset();
    lock_up();
    send_payload(12, 0, 1'b1);

    // 3: overlapped hunt, then wrong word at the check point drops to HUNT
    do_reset();
    send_bit(1'b0, 1'b0, 1'b0, 4'd0);
    send_bit(1'b1, 1'b0, 1'b0, 4'd0);
    send_word(4'b0110, 1'b1, 1'b0);
    send_payload(12, 0, 1'b0);
    send_word(4'b1001, 1'b0, 1'b0);
    send_word(4'b0110, 1'b1, 1'b0);

    // 4: miss tolerance, miss clearing, then loss of lock
    do_reset();
    lock_up();
    send_payload(12, 0, 1'b1);
    send_word(4'b0110, 1'b1, 1'b1);
    send_payload(12, 0, 1'b1);
    send_word(4'b0100, 1'b0, 1'b1);
    send_payload(12, 0, 1'b1);
    send_word(4'b0110, 1'b1, 1'b1);
    send_payload(12, 0, 1'b1);
    send_word(4'b0100, 1'b0, 1'b1);
    send_payload(12, 0, 1'b1);
    send_word(4'b1111, 1'b0, 1'b0);
    send_word(4'b1111, 1'b0, 1'b0);
    send_word(4'b1111, 1'b0, 1'b0);

    // 5: en stall mid-payload keeps index and alignment
    do_reset();
    lock_up();
    send_payload(6, 0, 1'b1);
    idle(5);
    send_payload(6, 6, 1'b1);
    send_word(4'b0110, 1'b1, 1'b1);
    send_payload(3, 0, 1'b1);

    // 6: async reset mid-payload, then a fresh hunt is required
    do_reset();
    lock_up();
    send_payload(5, 0, 1'b1);
    do_reset();
    send_bit(1'b1, 1'b0, 1'b0, 4'd0);
    send_bit(1'b1, 1'b0, 1'b0, 4'd0);
    send_bit(1'b0, 1'b0, 1'b0, 4'd0);
    send_word(4'b0110, 1'b1, 1'b0);
    idle(3);

    repeat (2) @(negedge clk);
    #1;
    chk_eq("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
